// File: rtl/gain_scale_pipe.sv
// gain_scale_pipe
//   Multiplies each signed waveform sample by a Q2.10 gain and adds a signed
//   DC offset. The result is saturated to 12 bits and sent to the DAC as
//   offset-binary. A newly loaded gain is held pending. It becomes active
//   only when a start-of-period sample arrives, so a waveform period never
//   changes amplitude part way through.
//
// Ports
//   Clock        in   system clock (rising edge)
//   Reset        in   synchronous reset, active low
//   Sample_In    in   [11:0] signed sample
//   Sample_Valid in   Sample_In valid this cycle
//   Sample_Sop   in   first sample of a waveform period (qualified by valid)
//   Gain_In      in   [11:0] unsigned Q2.10 gain
//   Gain_Load    in   strobe: capture Gain_In as pending gain
//   Offset_In    in   [11:0] signed DC offset, sampled with each sample
//   Sat_Clr      in   clears Sat_Flag
//   Dac_Out      out  [11:0] offset-binary DAC code (holds when not valid)
//   Dac_Valid    out  Dac_Out valid this cycle
//   Sat_Flag     out  sticky saturation indicator
//   Gain_Active  out  [11:0] gain applied to samples entering now
module gain_scale_pipe #(
   parameter logic [11:0] GAIN_RST = 12'd1024,
   parameter logic [11:0] DAC_RST  = 12'h800
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [11:0] Sample_In,
   input  logic        Sample_Valid,
   input  logic        Sample_Sop,
   input  logic [11:0] Gain_In,
   input  logic        Gain_Load,
   input  logic [11:0] Offset_In,
   input  logic        Sat_Clr,
   output logic [11:0] Dac_Out,
   output logic        Dac_Valid,
   output logic        Sat_Flag,
   output logic [11:0] Gain_Active
);

   logic [11:0] pend_gain;
   logic        pend_flag;
   logic        commit;
   logic [11:0] eff_gain;

   logic [11:0] s1_sample;
   logic [11:0] s1_gain;
   logic [11:0] s1_offset;
   logic        s1_valid;

   logic signed [24:0] prod;
   logic signed [24:0] rnd;
   logic               unused_rnd_lsb;

   logic [14:0] s2_res;
   logic [11:0] s2_offset;
   logic        s2_valid;

   logic signed [15:0] sum;
   logic [11:0]        clamped;
   logic               clipped;

   // A commit needs the pending flag as it was before this edge. A Gain_Load
   // in the same cycle only refills the pending register for the next period.
   always_comb begin
      commit   = Sample_Valid && Sample_Sop && pend_flag;
      eff_gain = commit ? pend_gain : Gain_Active;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         pend_gain   <= '0;
         pend_flag   <= 1'b0;
         Gain_Active <= GAIN_RST;
      end else begin
         if (commit) begin
            Gain_Active <= pend_gain;
         end
         if (Gain_Load) begin
            pend_gain <= Gain_In;
            pend_flag <= 1'b1;
         end else if (commit) begin
            pend_flag <= 1'b0;
         end
      end
   end

   // Stage 1: register inputs together with the gain that applies to them.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= Sample_Valid;
      end
      s1_sample <= Sample_In;
      s1_gain   <= eff_gain;
      s1_offset <= Offset_In;
   end

   // Stage 2: the gain is zero-extended to 13 bits and treated as a positive
   // signed value. The rounding constant 512 is half of one LSB after the
   // shift, so results round half-up. Bits [24:10] are the product after an
   // arithmetic shift right by 10.
   always_comb begin
      prod           = $signed(s1_sample) * $signed({1'b0, s1_gain});
      rnd            = prod + 25'sd512;
      unused_rnd_lsb = ^rnd[9:0];
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
      end
      s2_res    <= rnd[24:10];
      s2_offset <= s1_offset;
   end

   // Stage 3: add the offset, clamp to 12-bit signed, then convert to offset binary.
   always_comb begin
      sum     = $signed({s2_res[14], s2_res}) + $signed({{4{s2_offset[11]}}, s2_offset});
      clamped = sum[11:0];
      clipped = 1'b0;
      if (sum > 16'sd2047) begin
         clamped = 12'h7FF;
         clipped = 1'b1;
      end else if (sum < -16'sd2048) begin
         clamped = 12'h800;
         clipped = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         Dac_Out   <= DAC_RST;
         Dac_Valid <= 1'b0;
         Sat_Flag  <= 1'b0;
      end else begin
         Dac_Valid <= s2_valid;
         if (s2_valid) begin
            Dac_Out <= {~clamped[11], clamped[10:0]};
         end
         if (s2_valid && clipped) begin
            Sat_Flag <= 1'b1;
         end else if (Sat_Clr) begin
            Sat_Flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gain_scale_pipe.sv
module tb_gain_scale_pipe;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [11:0] Sample_In = '0;
   logic        Sample_Valid = 1'b0;
   logic        Sample_Sop = 1'b0;
   logic [11:0] Gain_In = '0;
   logic        Gain_Load = 1'b0;
   logic [11:0] Offset_In = '0;
   logic        Sat_Clr = 1'b0;
   logic [11:0] Dac_Out;
   logic        Dac_Valid;
   logic        Sat_Flag;
   logic [11:0] Gain_Active;

   gain_scale_pipe #(.GAIN_RST(12'd1024), .DAC_RST(12'h800)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Sample_In   (Sample_In),
      .Sample_Valid(Sample_Valid),
      .Sample_Sop  (Sample_Sop),
      .Gain_In     (Gain_In),
      .Gain_Load   (Gain_Load),
      .Offset_In   (Offset_In),
      .Sat_Clr     (Sat_Clr),
      .Dac_Out     (Dac_Out),
      .Dac_Valid   (Dac_Valid),
      .Sat_Flag    (Sat_Flag),
      .Gain_Active (Gain_Active)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [11:0] dac;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   // Monitor: every valid output must match the oldest outstanding
   // expectation and appear exactly 3 cycles after the sample was presented.
   always @(negedge Clock) begin
      if (Dac_Valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: Dac_Out=%h with nothing expected (cycle %0d)", Dac_Out, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (Dac_Out !== e.dac || (cyc - e.cyc) != 3) begin
               n_bad++;
               $display("FAIL dac_out: got %h after %0d cycles, expected %h after 3 cycles",
                        Dac_Out, cyc - e.cyc, e.dac);
            end
         end
      end
   end

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // One clock cycle of stimulus. Inputs are applied 1 time unit after the
   // rising edge. If v is set and chk is set, the expected DAC code is queued.
   task automatic step(input bit v, input bit sop, input logic [11:0] s, input logic [11:0] off,
                       input bit ld, input logic [11:0] g, input bit clr, input bit rst,
                       input logic [11:0] exp_dac, input bit chk);
      exp_t e;
      Sample_Valid = v;
      Sample_Sop   = sop;
      Sample_In    = s;
      Offset_In    = off;
      Gain_Load    = ld;
      Gain_In      = g;
      Sat_Clr      = clr;
      Reset        = ~rst;
      if (v && chk) begin
         e.dac = exp_dac;
         e.cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic smp(input bit sop, input logic [11:0] s, input logic [11:0] off, input logic [11:0] exp_dac);
      step(1'b1, sop, s, off, 1'b0, '0, 1'b0, 1'b0, exp_dac, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic load(input logic [11:0] g);
      step(1'b0, 1'b0, '0, '0, 1'b1, g, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic clr_cycle();
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected it to end", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge Clock);
      #1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
      check("rst_dac_out", Dac_Out, 12'h800);
      check("rst_dac_valid", {11'b0, Dac_Valid}, 12'h000);
      check("rst_sat_flag", {11'b0, Sat_Flag}, 12'h000);
      check("rst_gain_active", Gain_Active, 12'd1024);

      // Unity gain: output is the sample itself plus the offset.
      smp(1'b0, 12'd256, 12'd0, 12'h900);
      smp(1'b0, 12'd2047, 12'd0, 12'hFFF);
      smp(1'b0, 12'h800, 12'd0, 12'h000);
      idle(5);
      check("unity_gain_active", Gain_Active, 12'd1024);
      check("edge_no_sat", {11'b0, Sat_Flag}, 12'h000);

      // Positive saturation, then clearing the flag, then a clear in the same
      // cycle as a saturating output (the set must win).
      load(12'd2048);
      smp(1'b1, 12'd1500, 12'd0, 12'hFFF);
      idle(5);
      check("gain_2048_active", Gain_Active, 12'd2048);
      check("pos_sat_flag", {11'b0, Sat_Flag}, 12'h001);
      clr_cycle();
      check("sat_clear", {11'b0, Sat_Flag}, 12'h000);
      smp(1'b0, 12'd1500, 12'd0, 12'hFFF);
      idle(1);
      clr_cycle();
      idle(3);
      check("sat_set_beats_clr", {11'b0, Sat_Flag}, 12'h001);
      clr_cycle();

      // Negative saturation, offset, and mute.
      load(12'd4095);
      smp(1'b1, 12'h800, 12'd0, 12'h000);
      load(12'd1024);
      smp(1'b1, 12'd100, 12'hF38, 12'h79C);
      load(12'd0);
      smp(1'b1, 12'd77, 12'd5, 12'h805);
      idle(4);
      check("neg_sat_flag", {11'b0, Sat_Flag}, 12'h001);
      clr_cycle();

      // Rounding at half gain.
      load(12'd512);
      smp(1'b1, 12'd3, 12'd0, 12'h802);
      smp(1'b0, 12'hFFD, 12'd0, 12'h7FF);
      smp(1'b0, 12'd1, 12'd0, 12'h801);
      idle(4);
      check("round_no_sat", {11'b0, Sat_Flag}, 12'h000);

      // Commit timing with a continuous stream of samples.
      load(12'd1024);
      smp(1'b1, 12'd100, 12'd0, 12'h864);
      step(1'b1, 1'b0, 12'd100, 12'd0, 1'b1, 12'd2048, 1'b0, 1'b0, 12'h864, 1'b1);
      smp(1'b0, 12'd100, 12'd0, 12'h864);
      smp(1'b0, 12'd100, 12'd0, 12'h864);
      check("gain_held_mid_period", Gain_Active, 12'd1024);
      step(1'b1, 1'b1, 12'd100, 12'd0, 1'b1, 12'd3072, 1'b0, 1'b0, 12'h8C8, 1'b1);
      check("gain_commit_at_sop", Gain_Active, 12'd2048);
      smp(1'b0, 12'd100, 12'd0, 12'h8C8);
      smp(1'b1, 12'd100, 12'd0, 12'h92C);
      check("gain_load_with_commit", Gain_Active, 12'd3072);
      // A load with nothing pending must wait for the following Sop.
      step(1'b1, 1'b1, 12'd100, 12'd0, 1'b1, 12'd1024, 1'b0, 1'b0, 12'h92C, 1'b1);
      check("no_commit_same_cycle", Gain_Active, 12'd3072);
      smp(1'b1, 12'd100, 12'd0, 12'h864);
      // When several loads arrive before an Sop, the last one is used.
      load(12'd512);
      load(12'd2048);
      smp(1'b1, 12'd100, 12'd0, 12'h8C8);
      idle(4);

      // Reset with samples in flight. A gain is left pending so the test can
      // confirm that reset discards it.
      load(12'd2048);
      step(1'b1, 1'b0, 12'd100, 12'd0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 12'd100, 12'd0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 12'd100, 12'd0, 1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
      check("midrst_dac_valid", {11'b0, Dac_Valid}, 12'h000);
      check("midrst_dac_out", Dac_Out, 12'h800);
      check("midrst_gain_active", Gain_Active, 12'd1024);
      idle(3);
      smp(1'b1, 12'd100, 12'd0, 12'h864);
      idle(5);
      check("post_rst_gain", Gain_Active, 12'd1024);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_outputs: %0d expected outputs never appeared, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
